// File: rtl/riscv_custom_issue_if.sv
// Request and writeback channels between the EX stage and the CEU issue front end.
// Signal names are written from the issue block's point of view.
interface riscv_custom_issue_if #(
   parameter int unsigned OPW = 7
);
   logic           req_valid_i;
   logic           req_ready_o;
   logic [OPW-1:0] req_operator_i;
   logic [31:0]    req_a_i;
   logic [31:0]    req_b_i;
   logic [4:0]     req_rd_i;

   logic           wb_valid_o;
   logic           wb_ready_i;
   logic [31:0]    wb_data_o;
   logic [4:0]     wb_rd_o;
   logic           wb_timeout_o;

   modport master (
      output req_valid_i, req_operator_i, req_a_i, req_b_i, req_rd_i, wb_ready_i,
      input  req_ready_o, wb_valid_o, wb_data_o, wb_rd_o, wb_timeout_o
   );

   modport slave (
      input  req_valid_i, req_operator_i, req_a_i, req_b_i, req_rd_i, wb_ready_i,
      output req_ready_o, wb_valid_o, wb_data_o, wb_rd_o, wb_timeout_o
   );
endinterface

// File: rtl/riscv_custom_issue.sv
// Issue/collect front end for the custom execution unit: single-cycle launch,
// wait on the CEU ready pulse, writeback with watchdog timeout and flush drain.
module riscv_custom_issue #(
   parameter int unsigned OPW            = 7,
   parameter int unsigned TIMEOUT_CYCLES = 8192
) (
   input  logic                clk,
   input  logic                rst_n,
   riscv_custom_issue_if.slave bus,
   output logic                ceu_enable_o,
   output logic [OPW-1:0]      ceu_operator_o,
   output logic [31:0]         ceu_operand_a_o,
   output logic [31:0]         ceu_operand_b_o,
   input  logic [31:0]         ceu_result_i,
   input  logic                ceu_ready_i,
   input  logic                flush_i,
   output logic                busy_o
);
   localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} stateE;

   stateE          state_q, state_d;
   logic [OPW-1:0] operator_q;
   logic [31:0]    operandA_q;
   logic [31:0]    operandB_q;
   logic [4:0]     rd_q;
   logic [CW-1:0]  cnt_q;
   logic [31:0]    wbData_q;
   logic           wbTimeout_q;
   logic           accept;
   logic           expired;

   assign accept  = (state_q == IDLE) && bus.req_valid_i && !flush_i;
   assign expired = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A flush that coincides with the CEU ready pulse has already consumed it, so no drain is needed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = ISSUE;
         end
         ISSUE: begin
            if (flush_i)          state_d = ceu_ready_i ? IDLE : DRAIN;
            else if (ceu_ready_i) state_d = RESP;
            else                  state_d = WAIT;
         end
         WAIT: begin
            if (flush_i)                     state_d = ceu_ready_i ? IDLE : DRAIN;
            else if (ceu_ready_i || expired) state_d = RESP;
         end
         RESP: begin
            if (flush_i || bus.wb_ready_i) state_d = IDLE;
         end
         DRAIN: begin
            if (ceu_ready_i || expired) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready_o = 1'b0;
      bus.wb_valid_o  = 1'b0;
      ceu_enable_o    = 1'b0;
      busy_o          = 1'b1;
      case (state_q)
         IDLE: begin
            bus.req_ready_o = !flush_i;
            busy_o          = 1'b0;
         end
         ISSUE:   ceu_enable_o   = 1'b1;
         RESP:    bus.wb_valid_o = 1'b1;
         default: ;
      endcase
   end

   // Only the first ready after launch is captured; the counter saturates at its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         operator_q  <= '0;
         operandA_q  <= '0;
         operandB_q  <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         wbData_q    <= '0;
         wbTimeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  operator_q <= bus.req_operator_i;
                  operandA_q <= bus.req_a_i;
                  operandB_q <= bus.req_b_i;
                  rd_q       <= bus.req_rd_i;
               end
            end
            ISSUE: begin
               cnt_q <= '0;
               if (ceu_ready_i) begin
                  wbData_q    <= ceu_result_i;
                  wbTimeout_q <= 1'b0;
               end
            end
            WAIT: begin
               if (ceu_ready_i) begin
                  wbData_q    <= ceu_result_i;
                  wbTimeout_q <= 1'b0;
               end else if (expired) begin
                  wbData_q    <= '0;
                  wbTimeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DRAIN: begin
               if (!ceu_ready_i && !expired) cnt_q <= cnt_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign ceu_operator_o   = operator_q;
   assign ceu_operand_a_o  = operandA_q;
   assign ceu_operand_b_o  = operandB_q;
   assign bus.wb_data_o    = wbData_q;
   assign bus.wb_rd_o      = rd_q;
   assign bus.wb_timeout_o = wbTimeout_q;
endmodule

// File: tb/tb_riscv_custom_issue.sv
// Randomised bench for riscv_custom_issue with a behavioural CEU stub and a
// specification-level reference model for results and writeback latency.
module tb_riscv_custom_issue;
   localparam int OPW = 7;
   localparam int TMO = 16;
   localparam logic [OPW-1:0] ALU_ADD  = 7'b0011000;
   localparam logic [OPW-1:0] ALU_SLTS = 7'b0000010;
   localparam logic [OPW-1:0] ALU_CLB  = 7'b0110101;
   localparam logic [OPW-1:0] OP_HANG  = 7'b1111111;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           flush = 1'b0;
   logic           ceuEnable;
   logic [OPW-1:0] ceuOperator;
   logic [31:0]    ceuA, ceuB, ceuResult;
   logic           ceuReady;
   logic           busy;
   int             totalChecks = 0;
   int             badChecks = 0;

   riscv_custom_issue_if #(.OPW(OPW)) bus();

   riscv_custom_issue #(.OPW(OPW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .ceu_enable_o   (ceuEnable),
      .ceu_operator_o (ceuOperator),
      .ceu_operand_a_o(ceuA),
      .ceu_operand_b_o(ceuB),
      .ceu_result_i   (ceuResult),
      .ceu_ready_i    (ceuReady),
      .flush_i        (flush),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   // CEU stub: ADD acts as find-first-set, SLTS as XOR (both single-cycle), CLB as iterative GCD, HANG never ready.
   logic        gcdBusy;
   logic [31:0] gx, gy;

   function automatic logic [31:0] stubFfs(input logic [31:0] a);
      logic [31:0] r = 32'd32;
      for (int i = 31; i >= 0; i--) if (a[i]) r = 32'(i);
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gcdBusy <= 1'b0;
         gx      <= '0;
         gy      <= '0;
      end else if (gcdBusy) begin
         if (gy == 0) begin
            gcdBusy <= 1'b0;
         end else begin
            gx <= gy;
            gy <= gx % gy;
         end
      end else if (ceuEnable && ceuOperator == ALU_CLB) begin
         gcdBusy <= 1'b1;
         gx      <= ceuA;
         gy      <= ceuB;
      end
   end

   always_comb begin
      ceuReady  = 1'b0;
      ceuResult = '0;
      if (gcdBusy) begin
         ceuReady  = (gy == 0);
         ceuResult = gx;
      end else if (ceuOperator == ALU_ADD) begin
         ceuReady  = 1'b1;
         ceuResult = stubFfs(ceuA);
      end else if (ceuOperator == ALU_SLTS) begin
         ceuReady  = 1'b1;
         ceuResult = ceuA ^ ceuB;
      end
   end

   // Reference model: what the writeback should carry and in which cycle after acceptance it appears.
   function automatic logic [31:0] refFfs(input logic [31:0] a);
      if (a == 0) return 32'd32;
      return 32'($clog2(a & (~a + 32'd1)));
   endfunction

   function automatic logic [31:0] refGcd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x = a;
      logic [31:0] y = b;
      logic [31:0] t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic int gcdSteps(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x = a;
      logic [31:0] y = b;
      logic [31:0] t;
      int n = 0;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
         n++;
      end
      return n;
   endfunction

   function automatic logic [31:0] refResult(input logic [OPW-1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_ADD:  return refFfs(a);
         ALU_SLTS: return a ^ b;
         ALU_CLB:  return refGcd(a, b);
         default:  return 32'd0;
      endcase
   endfunction

   function automatic int refLatency(input logic [OPW-1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_CLB: return gcdSteps(a, b) + 3;
         OP_HANG: return TMO + 2;
         default: return 2;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ctrl"}, 64'({bus.req_ready_o, bus.wb_valid_o, ceuEnable, busy, bus.wb_timeout_o, bus.wb_rd_o}),
                  64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0}));
      checkOutput({tag, "_data"}, {bus.wb_data_o, ceuA}, 64'd0);
      checkOutput({tag, "_opb"}, 64'({ceuB, ceuOperator}), 64'd0);
   endtask

   // Called #1 after a rising edge with the DUT idle; returns in the same phase with the DUT idle.
   task automatic applyStimulus(input logic [OPW-1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input int hold, input int flushAt);
      int cyc = 1;
      int enCnt = 0;
      bit stable = 1'b1;
      bit flushed = 1'b0;
      logic [31:0] expData;
      checkOutput("req_ready_idle", 64'(bus.req_ready_o), 64'd1);
      bus.req_valid_i    = 1'b1;
      bus.req_operator_i = op;
      bus.req_a_i        = a;
      bus.req_b_i        = b;
      bus.req_rd_i       = rd;
      @(posedge clk); #1;
      bus.req_valid_i    = 1'b0;
      bus.req_operator_i = ALU_SLTS;
      bus.req_a_i        = $urandom;
      bus.req_b_i        = $urandom;
      bus.req_rd_i       = 5'($urandom);
      while (!bus.wb_valid_o && !(flushed && !busy) && cyc < 100) begin
         if (ceuEnable) enCnt++;
         if (ceuA !== a || ceuB !== b || ceuOperator !== op) stable = 1'b0;
         if (cyc == flushAt) begin
            flush   = 1'b1;
            flushed = 1'b1;
         end
         @(posedge clk); #1;
         flush = 1'b0;
         cyc++;
      end
      checkOutput("in_budget", 64'(cyc < 100), 64'd1);
      checkOutput("enable_pulses", 64'(enCnt), 64'd1);
      checkOutput("operands_held", 64'(stable), 64'd1);
      if (flushAt > 0) begin
         checkOutput("flush_no_wb", 64'(bus.wb_valid_o), 64'd0);
         checkOutput("flush_idle", 64'(busy), 64'd0);
      end else begin
         expData = refResult(op, a, b);
         checkOutput("latency", 64'(cyc), 64'(refLatency(op, a, b)));
         checkOutput("wb_data", 64'(bus.wb_data_o), 64'(expData));
         checkOutput("wb_rd", 64'(bus.wb_rd_o), 64'(rd));
         checkOutput("wb_timeout", 64'(bus.wb_timeout_o), 64'(op == OP_HANG));
         for (int h = 0; h < hold; h++) begin
            bus.req_valid_i = 1'b1;
            checkOutput("resp_no_accept", 64'(bus.req_ready_o), 64'd0);
            @(posedge clk); #1;
            checkOutput("resp_held", 64'({bus.wb_valid_o, bus.wb_timeout_o, bus.wb_rd_o, bus.wb_data_o}),
                        64'({1'b1, op == OP_HANG, rd, expData}));
         end
         bus.req_valid_i = 1'b0;
         bus.wb_ready_i  = 1'b1;
         @(posedge clk); #1;
         bus.wb_ready_i = 1'b0;
         checkOutput("back_to_idle", 64'({busy, bus.req_ready_o, bus.wb_valid_o}), 64'(3'b010));
      end
   endtask

   initial begin
      bus.req_valid_i    = 1'b0;
      bus.req_operator_i = '0;
      bus.req_a_i        = '0;
      bus.req_b_i        = '0;
      bus.req_rd_i       = '0;
      bus.wb_ready_i     = 1'b0;
      #12;
      checkResetOutputs("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus(ALU_ADD, 32'h0001_0000, 32'h0, 5'd3, 0, 0);
      applyStimulus(ALU_CLB, 32'd48, 32'd18, 5'd7, 0, 0);
      applyStimulus(ALU_CLB, 32'd7, 32'd0, 5'd8, 0, 0);
      applyStimulus(ALU_SLTS, 32'hdead_beef, 32'h1234_5678, 5'd21, 5, 0);
      applyStimulus(OP_HANG, 32'd1, 32'd2, 5'd30, 1, 0);
      applyStimulus(ALU_CLB, 32'd48, 32'd18, 5'd11, 0, 4);
      applyStimulus(ALU_SLTS, 32'd5, 32'd3, 5'd9, 0, 0);

      flush = 1'b1;
      bus.req_valid_i = 1'b1;
      #1;
      checkOutput("flush_gates_ready", 64'(bus.req_ready_o), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      bus.req_valid_i = 1'b0;
      checkOutput("flush_idle_no_accept", 64'(busy), 64'd0);

      bus.req_valid_i    = 1'b1;
      bus.req_operator_i = OP_HANG;
      bus.req_rd_i       = 5'd17;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("reset_mid_wait");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(ALU_ADD, 32'h0000_0400, 32'h0, 5'd4, 0, 0);

      for (int i = 0; i < 30; i++) begin
         int sel = $urandom_range(0, 2);
         logic [OPW-1:0] op = (sel == 0) ? ALU_ADD : (sel == 1) ? ALU_SLTS : ALU_CLB;
         logic [31:0] a = (op == ALU_CLB) ? 32'($urandom_range(0, 255)) : $urandom;
         logic [31:0] b = (op == ALU_CLB) ? 32'($urandom_range(0, 255)) : $urandom;
         applyStimulus(op, a, b, 5'($urandom), $urandom_range(0, 2), 0);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] simulation did not finish");
   end
endmodule
